// File: rtl/hz_matrix_scan.sv
// Glyph ROM reader and 16x16 LED matrix row scanner: prefetches the next row into a
// shadow register while the current row is lit, and steps through the stored characters.
module hz_matrix_scan #(
  parameter int ROW_HOLD  = 1000,
  parameter int CHAR_HOLD = 50,
  parameter int NUM_CHARS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        pause,
  output logic [6:0]  rom_addr,
  input  logic [7:0]  rom_dout,
  output logic [15:0] row_sel,
  output logic [15:0] col_data,
  output logic [1:0]  char_idx,
  output logic        frame_start
);

  localparam int CNT_W = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;
  localparam int FC_W  = (CHAR_HOLD > 1) ? $clog2(CHAR_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ROW_HOLD - 1);
  localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(CHAR_HOLD - 1);
  localparam logic [1:0]       CHAR_LAST = 2'(NUM_CHARS - 1);

  typedef enum logic [1:0] {PRIME_F0, PRIME_F1, PRIME_F2, DISPLAY} state_t;

  state_t           state;
  logic [3:0]       row;
  logic [CNT_W-1:0] cnt;
  logic [FC_W-1:0]  frame_cnt;
  logic [15:0]      shadow;
  logic [1:0]       pf_char;
  logic             adv;

  logic             adv_n;
  logic [1:0]       char_inc;
  logic [1:0]       pf_char_n;
  logic [3:0]       pf_row;

  // The advance decision is frozen when row 15 goes up, so both halves of the
  // row-0 prefetch and the char_idx update always agree on the same glyph.
  always_comb begin
    char_inc  = (char_idx == CHAR_LAST) ? 2'd0 : char_idx + 2'd1;
    adv_n     = (frame_cnt == FC_LAST) && !pause;
    pf_row    = row + 4'd2;
    pf_char_n = pf_char;
    if (row == 4'd14)
      pf_char_n = adv_n ? char_inc : char_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PRIME_F0;
      rom_addr    <= '0;
      row_sel     <= '0;
      col_data    <= '0;
      char_idx    <= '0;
      frame_start <= 1'b0;
      row         <= '0;
      cnt         <= '0;
      frame_cnt   <= '0;
      pf_char     <= '0;
      adv         <= 1'b0;
    end else if (!en) begin
      state       <= PRIME_F0;
      rom_addr    <= {char_idx, 4'd0, 1'b0};
      row_sel     <= '0;
      col_data    <= '0;
      frame_start <= 1'b0;
      row         <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        PRIME_F0: begin
          rom_addr    <= {char_idx, 4'd0, 1'b1};
          frame_start <= 1'b0;
          state       <= PRIME_F1;
        end
        PRIME_F1: begin
          shadow[15:8] <= rom_dout;
          state        <= PRIME_F2;
        end
        PRIME_F2: begin
          col_data    <= {shadow[15:8], rom_dout};
          row_sel     <= 16'h0001;
          frame_start <= 1'b1;
          row         <= '0;
          cnt         <= '0;
          pf_char     <= char_idx;
          rom_addr    <= {char_idx, 4'd1, 1'b0};
          state       <= DISPLAY;
        end
        default: begin
          frame_start <= 1'b0;
          if (cnt == '0)
            rom_addr[0] <= 1'b1;
          if (cnt == CNT_W'(1))
            shadow[15:8] <= rom_dout;
          if (cnt == CNT_W'(2))
            shadow[7:0] <= rom_dout;
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            row      <= row + 4'd1;
            row_sel  <= {row_sel[14:0], row_sel[15]};
            col_data <= shadow;
            rom_addr <= {pf_char_n, pf_row, 1'b0};
            pf_char  <= pf_char_n;
            if (row == 4'd14)
              adv <= adv_n;
            if (row == 4'd15) begin
              frame_start <= 1'b1;
              if (adv) begin
                char_idx  <= pf_char;
                frame_cnt <= '0;
              end else if (frame_cnt != FC_LAST) begin
                frame_cnt <= frame_cnt + 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hz_matrix_scan.sv
// Bench for hz_matrix_scan: registered glyph ROM, start-up vector table, scripted
// corner cases and a randomized run, all checked against a frame-level reference model.
module tb_hz_matrix_scan;

  localparam int RH = 8;
  localparam int CH = 2;
  localparam int NC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        pause = 1'b0;
  logic [6:0]  rom_addr;
  logic [7:0]  rom_dout;
  logic [15:0] row_sel;
  logic [15:0] col_data;
  logic [1:0]  char_idx;
  logic        frame_start;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [15:0] g [0:3][0:15];

  hz_matrix_scan #(.ROW_HOLD(RH), .CHAR_HOLD(CH), .NUM_CHARS(NC)) dut (
    .clk(clk), .rst(rst), .en(en), .pause(pause), .rom_addr(rom_addr),
    .rom_dout(rom_dout), .row_sel(row_sel), .col_data(col_data),
    .char_idx(char_idx), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    rom_dout <= rom_addr[0] ? g[rom_addr[6:5]][rom_addr[4:1]][7:0]
                            : g[rom_addr[6:5]][rom_addr[4:1]][15:8];

  // Reference model state: prime step or displayed row/period position per character
  int          m_mode = 0, m_pk = 0, m_row = 0, m_cnt = 0, m_ch = 0, m_fc = 0, m_nch = 0;
  bit          m_adv = 1'b0;
  logic [15:0] exp_rs = '0, exp_cd = '0;
  logic        exp_fs = 1'b0;

  task automatic model_step();
    if (rst) begin
      m_mode = 0; m_pk = 0; m_row = 0; m_cnt = 0; m_ch = 0; m_fc = 0;
      exp_rs = '0; exp_cd = '0; exp_fs = 1'b0;
    end else if (!en) begin
      m_mode = 0; m_pk = 0; m_row = 0; m_cnt = 0;
      exp_rs = '0; exp_cd = '0; exp_fs = 1'b0;
    end else if (m_mode == 0) begin
      exp_fs = 1'b0;
      if (m_pk < 2) m_pk++;
      else begin
        m_mode = 1; m_row = 0; m_cnt = 0;
        exp_rs = 16'd1; exp_cd = g[m_ch][0]; exp_fs = 1'b1;
      end
    end else begin
      exp_fs = 1'b0;
      if (m_cnt < RH - 1) m_cnt++;
      else begin
        m_cnt = 0;
        m_row = (m_row + 1) % 16;
        exp_rs = 16'd1 << m_row;
        if (m_row == 15) begin
          m_adv = (m_fc == CH - 1) && !pause;
          m_nch = m_adv ? (m_ch + 1) % NC : m_ch;
        end
        if (m_row == 0) begin
          exp_fs = 1'b1;
          if (m_adv) begin m_ch = m_nch; m_fc = 0; end
          else if (m_fc < CH - 1) m_fc++;
        end
        exp_cd = g[m_ch][m_row];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    vectors++;
    if (row_sel !== exp_rs || col_data !== exp_cd || frame_start !== exp_fs ||
        char_idx !== 2'(m_ch)) begin
      miscompares++;
      $display("FAIL model cyc=%0d row_sel=%h want %h col_data=%h want %h fs=%b want %b char=%0d want %0d",
               cyc, row_sel, exp_rs, col_data, exp_cd, frame_start, exp_fs, char_idx, m_ch);
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, want);
    end
  endtask

  task automatic wait_fs(input string name);
    int n = 0;
    do begin tick(); n++; end while (!frame_start && n < 400);
    check(name, {15'd0, frame_start}, 16'd1);
  endtask

  typedef struct {
    logic        r, e, p;
    logic [6:0]  addr;
    logic [15:0] rs, cd;
    logic        fs;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int seq [6];
    int c;
    for (int ci = 0; ci < 4; ci++)
      for (int ri = 0; ri < 16; ri++)
        g[ci][ri] = 16'($urandom);
    g[0][0] = 16'h1000; g[0][1] = 16'h11F8; g[0][3] = 16'h1020;
    g[1][0] = 16'h0040; g[2][0] = 16'h1FE0; g[2][15] = 16'h0200;

    // Reset release and first row period
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 7'd0, 16'h0000, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 7'd1, 16'h0000, 16'h0000, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 7'd1, 16'h0000, 16'h0000, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 7'd2, 16'h0001, 16'h1000, 1'b1};
    for (int i = 4; i <= 10; i++)
      tbl[i] = '{1'b0, 1'b1, 1'b0, 7'd3, 16'h0001, 16'h1000, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 7'd4, 16'h0002, 16'h11F8, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 7'd5, 16'h0002, 16'h11F8, 1'b0};

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].r; en = tbl[i].e; pause = tbl[i].p;
      tick();
      check($sformatf("t%0d_addr", i), {9'd0, rom_addr}, {9'd0, tbl[i].addr});
      check($sformatf("t%0d_rs", i), row_sel, tbl[i].rs);
      check($sformatf("t%0d_cd", i), col_data, tbl[i].cd);
      check($sformatf("t%0d_fs", i), {15'd0, frame_start}, {15'd0, tbl[i].fs});
    end
    check("reset_char", {14'd0, char_idx}, 16'd0);

    // Character sequence over six frame ends with CHAR_HOLD=2
    seq = '{0, 1, 1, 2, 2, 0};
    for (int k = 0; k < 6; k++) begin
      wait_fs($sformatf("s3_fs%0d", k));
      check($sformatf("s3_char%0d", k), {14'd0, char_idx}, 16'(seq[k]));
    end

    // Pause held across five frame ends, then release
    wait_fs("s4_sync");
    pause = 1'b1;
    c = int'(char_idx);
    for (int k = 0; k < 5; k++) begin
      wait_fs($sformatf("s4_fs%0d", k));
      check($sformatf("s4_hold%0d", k), {14'd0, char_idx}, 16'(c));
    end
    pause = 1'b0;
    wait_fs("s4_rel_fs");
    check("s4_adv", {14'd0, char_idx}, 16'((c + 1) % NC));

    // en dropped during row 7 of character 1
    for (int n = 0; n < 1500 && !(char_idx == 2'd1 && row_sel == 16'h0080); n++) tick();
    check("s5_reach", {15'd0, (char_idx == 2'd1 && row_sel == 16'h0080)}, 16'd1);
    en = 1'b0;
    tick();
    check("s5_off_rs", row_sel, 16'h0000);
    check("s5_off_cd", col_data, 16'h0000);
    en = 1'b1;
    tick(); tick();
    check("s5_prime_rs", row_sel, 16'h0000);
    tick();
    check("s5_on_rs", row_sel, 16'h0001);
    check("s5_on_cd", col_data, 16'h0040);
    check("s5_on_char", {14'd0, char_idx}, 16'd1);

    // rst pulsed mid-frame while character 2 is shown
    for (int n = 0; n < 1500 && !(char_idx == 2'd2 && row_sel == 16'h0020); n++) tick();
    check("s6_reach", {15'd0, (char_idx == 2'd2 && row_sel == 16'h0020)}, 16'd1);
    rst = 1'b1;
    tick();
    check("s6_rst_rs", row_sel, 16'h0000);
    check("s6_rst_cd", col_data, 16'h0000);
    check("s6_rst_char", {14'd0, char_idx}, 16'd0);
    check("s6_rst_addr", {9'd0, rom_addr}, 16'd0);
    rst = 1'b0;
    tick();
    check("s6_e0_addr", {9'd0, rom_addr}, 16'd1);
    tick(); tick();
    check("s6_rs", row_sel, 16'h0001);
    check("s6_cd", col_data, 16'h1000);
    check("s6_fs", {15'd0, frame_start}, 16'd1);

    // Randomized run: occasional pause toggles, enable drops and resets
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 199) == 0) pause = ~pause;
      if (!en) en = ($urandom_range(0, 3) == 0);
      else     en = ($urandom_range(0, 249) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hz_matrix_scan.md
Name: hz_matrix_scan

Overview:
- Reader/consumer side of the 16x16 Hanzi glyph ROM (7-bit address, 8-bit data, one registered read per clock).
- Fetches glyph rows from the ROM and drives a 16x16 LED dot matrix, one row at a time.
- Automatically cycles through the stored characters.
- Sits between the glyph ROM and the matrix row/column driver pins.

Parameters:
- ROW_HOLD, 1000: clocks each row is displayed. Must be >= 4.
- CHAR_HOLD, 50: full frames (16 rows) shown per character before advancing.
- NUM_CHARS, 3: number of glyphs in the ROM, 1..4. The ROM holds 32 bytes per glyph.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  display enable
- pause  in  1  hold current character (suppress advance)
- rom_addr  out  7  ROM address {char_idx[1:0], row[3:0], half}; half=0 is left byte
- rom_dout  in  8  ROM data, valid one clock after rom_addr is sampled
- row_sel  out  16  one-hot row select, active-high, bit0 = top row
- col_data  out  16  column pixels, active-high, bit15 = leftmost column
- char_idx  out  2  character currently displayed
- frame_start  out  1  one-clock pulse when row 0 is loaded

Behaviour:
- Reset values: rom_addr=0, row_sel=0, col_data=0, char_idx=0, frame_start=0. Internal counters are 0 and the FSM is in PRIME_F0.
- ROM read timing:
  - rom_addr is a register. The ROM samples it at the next edge, and its output is captured one edge after that.
  - Fetching one row takes three states: F0 drives addr hi, F1 drives addr lo, F2 has lo data arriving.
  - Hi byte is captured at the end of F1; lo byte at the end of F2.
- Start-up (PRIME), with E0 = first edge where rst=0:
  - E0: rom_addr <= {char,row0,1}.
  - E1: shadow[15:8] <= rom_dout.
  - E2: col_data <= {shadow[15:8], rom_dout}; row_sel <= 16'h0001; frame_start=1 for that one cycle; enter DISPLAY with row period counter = 0.
- DISPLAY double-buffers rows:
  - Row period counter runs 0..ROW_HOLD-1.
  - Counts 0..2 prefetch the next row into the shadow register using the same F0/F1/F2 sequence. The next row is (row+1) mod 16.
  - At count ROW_HOLD-1, the next edge loads col_data from the shadow, rotates row_sel left by one (bit15 wraps to bit0), and resets the counter.
  - The displayed row only changes at the period boundary.
- Character advance:
  - While row 15 is displayed, next_char is computed for the row-0 prefetch.
  - next_char = char_idx+1 (wrapping NUM_CHARS-1 -> 0) when frame_cnt==CHAR_HOLD-1 and pause=0; otherwise next_char = char_idx.
  - char_idx and frame_cnt update on the same edge that loads row 0. frame_cnt resets to 0 when the character advances.
  - frame_start pulses on every row-0 load.
- pause=1: frame_cnt saturates at CHAR_HOLD-1 and char_idx holds. Deasserting pause gives an advance at the next frame end.
- en=0 (sampled at any edge):
  - Next edge: row_sel=0, col_data=0, FSM returns to PRIME_F0 with row=0, rom_addr={char_idx,0,0}.
  - char_idx and frame_cnt are retained.
  - Re-asserting en repeats the PRIME timing above, starting from row 0.
- rst mid-operation: all state returns to reset values at the next edge, including char_idx=0. rst overrides en.
- rom_addr changes only during F0/F1 states. It is held stable at the last issued address otherwise.
- NUM_CHARS=1: char_idx stays 0 permanently.

Test Plan:
1. Reset release, ROW_HOLD=8, CHAR_HOLD=2, NUM_CHARS=3 -> rom_addr 0,1. After the 3rd edge with rst low: row_sel=0x0001, col_data=0x1000, frame_start=1 for one clock.
2. Continue -> 8 clocks later row_sel=0x0002, col_data=0x11F8. Row 3 shows 0x1020. After row 15, row_sel wraps to 0x0001.
3. Run 2 full frames -> char_idx=1, first row col_data=0x0040. After 2 more frames: char_idx=2, row0=0x1FE0, row15=0x0200. After 2 more frames: char_idx wraps to 0, row0=0x1000.
4. pause=1 held across 5 frame ends -> char_idx unchanged, frame_start still pulses each frame. Release pause -> advance at the next frame end.
5. en=0 during row 7 of char 1 -> next clock row_sel=0, col_data=0. en=1 -> 3 clocks later row_sel=0x0001 with char 1 row0 = 0x0040.
6. rst pulsed mid-frame while char_idx=2 -> next clock all outputs 0, char_idx=0. After release, same timing as scenario 1.
